// File: rtl/uart_sim_pkg.sv
// uart_sim_pkg: FSM encoding, data width and bit-period helper shared by the UART sim blocks
package uart_sim_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int DATA_BITS = 8;
  function automatic int calc_div(input int clock_freq, input int baud_rate);
    int d;
    d = clock_freq / baud_rate;
    return (d < 1) ? 1 : d;
  endfunction
endpackage

// File: rtl/uart_sim_fifo.sv
// uart_sim_fifo: byte queue with wrap-bit pointers decoding full/empty
module uart_sim_fifo
  import uart_sim_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic do_push, do_pop;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = wr_q == rd_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[AW-1:0]];
  // advance each pointer only on an accepted transfer; wrap is implicit
  always_comb begin
    wr_d = do_push ? wr_q + PTR_ONE : wr_q;
    rd_d = do_pop ? rd_q + PTR_ONE : rd_q;
  end
  // pointer registers, cleared asynchronously to an empty queue
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // storage needs no reset: the pointers define which entries are valid
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/uart_sim_transmitter.sv
// uart_sim_transmitter: queued 8N1 serial transmitter with registered line output
module uart_sim_transmitter
  import uart_sim_pkg::*;
#(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 19200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 txd_o,
  output logic                 busy_o
);
  localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_BITS - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, fifo_data;
  logic txd_q, txd_d;
  logic pop, full, empty, tc;
  uart_sim_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (valid_i),
    .pop_i  (pop),
    .data_i (data_i),
    .data_o (fifo_data),
    .full_o (full),
    .empty_o(empty)
  );
  assign ready_o = !full;
  assign busy_o  = (state_q != IDLE) || !empty;
  assign txd_o   = txd_q;
  assign tc      = cnt_q == CNT_MAX;
  // frame sequencing: baud counter runs outside IDLE, bits advance on terminal count
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    if (state_q != IDLE) cnt_d = tc ? '0 : cnt_q + CW'(1);
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        sh_d    = fifo_data;
        bit_d   = '0;
        state_d = START;
      end
      START: if (tc) state_d = DATA;
      DATA: if (tc) begin
        sh_d    = sh_q >> 1;
        bit_d   = bit_q + BW'(1);
        state_d = (bit_q == BIT_MAX) ? STOP : DATA;
      end
      STOP: if (tc) state_d = IDLE;
    endcase
    txd_d = (state_q == START) ? 1'b0 : (state_q == DATA) ? sh_q[0] : 1'b1;
  end
  // state and datapath registers; reset aborts any frame and idles the line
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
    end
  end
endmodule

// File: doc/uart_sim_transmitter.md
UART_SIM_TRANSMITTER -- requirements
Module: uart_sim_transmitter

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 100000000, core clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 19200, serial bit rate in bit/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, TX queue entries (power of two, >= 2).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk_i  input  1  rising-edge clock.
REQ-006 SHALL have port rst_i  input  1  asynchronous active-high reset.
REQ-007 SHALL have port data_i  input  8  byte to transmit.
REQ-008 SHALL have port valid_i  input  1  data_i valid.
REQ-009 SHALL have port ready_o  output  1  queue can accept a byte.
REQ-010 SHALL have port txd_o  output  1  serial line, idle high; connects to the core's uart0_rxd_i.
REQ-011 SHALL have port busy_o  output  1  frame in flight or queue non-empty.

Function
REQ-012 SHALL set bit period DIV = CLOCK_FREQ/BAUD_RATE (integer division, minimum 1); 100 MHz / 19200 gives 5208 cycles.
REQ-013 SHALL accept a byte on a rising edge where valid_i=1 and ready_o=1; otherwise no write.
REQ-014 SHALL drive ready_o = not full, with no bypass path; a pop while full does not enable a same-cycle push.
REQ-015 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-016 In IDLE with a non-empty queue, it SHALL pop one byte into the shift register and enter START on that edge; with an empty queue it SHALL stay in IDLE.
REQ-017 SHALL drive txd_o low for exactly DIV cycles in START, then enter DATA.
REQ-018 In DATA, it SHALL send 8 bits, LSB first, each for exactly DIV cycles, using a 3-bit bit counter; it SHALL enter STOP after bit 7.
REQ-019 In STOP, it SHALL drive txd_o high for DIV cycles, then return to IDLE.
REQ-020 SHALL form an 8N1 frame of exactly 10*DIV cycles.
REQ-021 SHALL put a back-to-back inter-frame gap of exactly 1 cycle (the IDLE evaluation cycle).
REQ-022 Latency: a byte accepted into an empty queue while IDLE SHALL make txd_o fall after the second rising edge following acceptance.
REQ-023 SHALL keep txd_o registered and glitch-free, high in IDLE and STOP.
REQ-024 SHALL drive busy_o = (state != IDLE) or queue non-empty.
REQ-025 Baud counter: it SHALL count 0..DIV-1 and wrap; bit advance occurs only on the terminal count.
REQ-026 SHALL use FIFO read/write pointers one bit wider than log2(FIFO_DEPTH); full/empty are decoded from MSB mismatch or equality; pointers wrap silently.
REQ-027 On simultaneous push and pop on a non-full, non-empty queue, the count SHALL stay unchanged and ordering SHALL be preserved.

Reset
REQ-028 rst_i SHALL asynchronously force: state=IDLE, txd_o=1, FIFO empty, pointers=0, counters=0, busy_o=0, ready_o=1.
REQ-029 Reset mid-frame SHALL abort the frame immediately: txd_o goes high, queued bytes are discarded, and no partial frame resumes after release.

Structure
REQ-030 SHALL keep in the shared package uart_sim_pkg: the FSM state encoding, DATA_BITS=8, and the DIV computation function shared with uart_sim_receiver.
REQ-031 SHALL place the queue in sub-module uart_sim_fifo (parameter FIFO_DEPTH, width 8, push/pop/full/empty).

Verification
REQ-032 Single byte 0x4E at 100 MHz / 19200 -> txd_o is low for 5208 cycles, then bits 0,1,1,1,0,0,1,0 at 5208 cycles each, then high for 5208 cycles; busy_o falls 1 cycle after the stop bit ends.
REQ-033 Loopback into uart_sim_receiver with the string "NEORV32" pushed back-to-back -> the receiver outputs the 7 bytes in order, and the frame gap measures 1 cycle.
REQ-034 valid_i held high with 6 distinct bytes from idle -> 5 bytes accepted (1 in flight + 4 queued), then ready_o=0; ready_o returns to 1 on the cycle after the next pop; byte order is preserved.
REQ-035 rst_i asserted in the middle of DATA bit 3 with 2 bytes queued -> txd_o=1 immediately; after release busy_o=0, ready_o=1, and no further start bit appears.
REQ-036 CLOCK_FREQ=BAUD_RATE (DIV=1) with byte 0xA5 -> a 10-cycle frame: 0,1,0,1,0,0,1,0,1,1.
